// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, valid/ready in, done pulse out.
// Optional ALU_FAST_MUL_EN: multiplies use a single-cycle W x W multiplier and complete in one cycle.
module alu_muldiv_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [OP_WIDTH-1:0]   op_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(6);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [OP_WIDTH-1:0] op_q;
    logic [W-1:0]    b_q;
    logic [2*W:0]    acc_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q, neg_r_q;
    logic [W-1:0]    result_q;

    logic            accept, fast, last;
    logic            is_div, op1_sgn, op2_sgn, neg1, neg2;
    logic [W-1:0]    mag1, mag2, fast_res, calc_res;
    logic            div_zero, div_ovf;

    // Operand decode and magnitude conversion on the request inputs
    always_comb begin
        is_div   = op_i[2];
        op1_sgn  = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
        op2_sgn  = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        neg1     = op1_sgn & op1_i[W-1];
        neg2     = op2_sgn & op2_i[W-1];
        mag1     = neg1 ? (~op1_i + 1'b1) : op1_i;
        mag2     = neg2 ? (~op2_i + 1'b1) : op2_i;
        div_zero = is_div && (op2_i == '0);
        div_ovf  = is_div && !op_i[0] && (op1_i == {1'b1, {(W-1){1'b0}}}) && (op2_i == '1);
    end

`ifdef ALU_FAST_MUL_EN
    logic [2*W-1:0] fm_prod, fm_fix;
    always_comb begin
        fm_prod = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
        fm_fix  = (neg1 ^ neg2) ? (~fm_prod + 1'b1) : fm_prod;
    end
`endif

    always_comb begin
        fast     = div_zero | div_ovf;
        fast_res = '0;
        if (div_zero)
            fast_res = op_i[1] ? op1_i : '1;
        else if (div_ovf)
            fast_res = op_i[1] ? '0 : op1_i;
`ifdef ALU_FAST_MUL_EN
        if (!is_div) begin
            fast     = 1'b1;
            fast_res = (op_i == OP_MUL) ? fm_fix[W-1:0] : fm_fix[2*W-1:W];
        end
`endif
    end

    // One iteration of either algorithm; acc holds {hi/rem, lo/quotient}
    logic [W:0]     mul_sum, diff;
    logic [2*W:0]   mul_step, div_step, shifted, acc_step;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo, rem;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_step = {mul_sum, acc_q[W-1:0]} >> 1;
        shifted  = {acc_q[2*W-1:0], 1'b0};
        diff     = shifted[2*W:W] - {1'b0, b_q};
        div_step = diff[W] ? shifted : {diff, shifted[W-1:1], 1'b1};
        acc_step = op_q[2] ? div_step : mul_step;

        prod_fix = neg_q ? (~acc_step[2*W-1:0] + 1'b1) : acc_step[2*W-1:0];
        quo      = neg_q ? (~acc_step[W-1:0] + 1'b1) : acc_step[W-1:0];
        rem      = neg_r_q ? (~acc_step[2*W-1:W] + 1'b1) : acc_step[2*W-1:W];
        case (op_q)
            OP_MUL:                     calc_res = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:            calc_res = quo;
            default:                    calc_res = rem;
        endcase
        last = (cnt_q == CW'(W - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        done_o  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                ready_o = 1'b1;
                done_o  = (state_q == DONE);
                accept  = valid_i & ~flush_i;
                if (accept) state_d = fast ? DONE : CALC;
                else        state_d = IDLE;
            end
            CALC: begin
                if (flush_i)   state_d = IDLE;
                else if (last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q    <= op_i;
            b_q     <= mag2;
            acc_q   <= {{(W+1){1'b0}}, mag1};
            cnt_q   <= '0;
            neg_q   <= neg1 ^ neg2;
            neg_r_q <= neg1;
            if (fast) result_q <= fast_res;
        end else if (state_q == CALC) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
            // A flush on the final iteration must leave the old result visible
            if (last && !flush_i) result_q <= calc_res;
        end
    end

    assign result_o = result_q;
    assign zero_o   = (result_q == '0);
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized + directed bench for alu_muldiv_seq against a plain-arithmetic RV32M model.
module tb_alu_muldiv_seq;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst, valid, flush;
    logic [2:0]  op;
    logic [31:0] op1, op2;
    logic        ready, done, zero;
    logic [31:0] result;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] last_res = '0;

    alu_muldiv_seq #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .op1_i(op1), .op2_i(op2),
        .flush_i(flush), .ready_o(ready), .done_o(done), .result_o(result), .zero_o(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q;
        logic [63:0] ua, ub, p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                q = sa / sb; return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && (b == 0)) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef ALU_FAST_MUL_EN
        if (!o[2]) return 1;
`endif
        return W + 1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one request in the current cycle; leaves us at cycle 1 with inputs scrambled
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        chk("issue_ready", {31'b0, ready}, 32'd1);
        valid = 1'b1; op = o; op1 = a; op2 = b;
        cyc();
        valid = 1'b0; op = 3'($urandom); op1 = $urandom; op2 = $urandom;
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [31:0] res);
        int k = 1;
        int busy_rdy = 0;
        while (!done && k < 200) begin
            if (ready) busy_rdy++;
            cyc();
            k++;
        end
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_res"}, result, res);
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, res == 0});
        chk({tag, "_busy_ready"}, busy_rdy, 0);
        last_res = res;
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit b2b);
        issue(o, a, b);
        wait_done(tag, lat_of(o, a, b), model(o, a, b));
        if (!b2b) begin
            cyc();
            chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; valid = 1'b0; flush = 1'b0; op = '0; op1 = '0; op2 = '0;
        #12;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        run("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run("divu", 3'd5, 32'd100, 32'd7, 1'b0);
        run("remu", 3'd7, 32'd100, 32'd7, 1'b0);
        run("div0", 3'd4, 32'd5, 32'd0, 1'b0);
        run("remu0", 3'd7, 32'd5, 32'd0, 1'b0);
        run("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Flush mid-calculation at cycle 10
        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) cyc();
        flush = 1'b1;
        chk("flush_nodone", {31'b0, done}, 32'd0);
        cyc();
        flush = 1'b0;
        chk("flush_ready", {31'b0, ready}, 32'd1);
        chk("flush_done", {31'b0, done}, 32'd0);
        chk("flush_keep", result, last_res);
        run("post_flush", 3'd5, 32'd9, 32'd3, 1'b0);

        // Flush during DONE keeps done_o but blocks the new request
        run("flush_in_done", 3'd5, 32'd50, 32'd5, 1'b1);
        flush = 1'b1; valid = 1'b1; op = 3'd4; op1 = 32'd77; op2 = 32'd0;
        chk("fd_done_held", {31'b0, done}, 32'd1);
        cyc();
        flush = 1'b0; valid = 1'b0;
        chk("fd_blocked_done", {31'b0, done}, 32'd0);
        chk("fd_blocked_res", result, 32'd10);

        // Back-to-back: accept in the DONE cycle
        run("b2b_a", 3'd7, 32'd23, 32'd5, 1'b1);
        run("b2b_b", 3'd0, 32'd6, 32'd7, 1'b1);
        run("b2b_c", 3'd5, 32'd8, 32'd0, 1'b0);

        // Async reset mid-CALC
        issue(3'd5, 32'd12345, 32'd17);
        repeat (4) cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", {31'b0, ready}, 32'd1);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                cyc();
                if (done) seen++;
            end
            chk("arst_no_done", seen, 0);
        end
        last_res = '0;

        for (int i = 0; i < 160; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run($sformatf("rnd%0d_op%0d", i, o), o, a, b, ($urandom_range(0, 3) == 0));
        end
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
